// File: rtl/spectral_flux_calc.sv
// Spectral flux: per-frame sum of half-wave-rectified bin-magnitude increases.
// Define SPECFLUX_MAXMIN_EN for the alpha-max-beta-min magnitude; the default is |re|+|im|.
module spectral_flux_calc #(
    parameter int N_BINS = 128,
    parameter int DATA_W = 16,
    parameter int FLUX_W = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    output logic                      o_rd_en,
    output logic [$clog2(N_BINS)-1:0] o_rd_addr,
    input  logic [DATA_W-1:0]         i_rd_real,
    input  logic [DATA_W-1:0]         i_rd_imag,
    output logic                      o_busy,
    output logic [FLUX_W-1:0]         o_flux,
    output logic                      o_flux_valid
);

    localparam int AW = $clog2(N_BINS);
    localparam int MW = DATA_W + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(N_BINS - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [AW-1:0]     r_addr;
    logic              r_drain;
    logic              r_rd_vld;
    logic [AW-1:0]     r_rd_idx;
    logic              r_mag_vld;
    logic [MW-1:0]     r_mag;
    logic [AW-1:0]     r_mag_idx;
    logic [FLUX_W-1:0] r_acc;
    logic [FLUX_W-1:0] r_flux;
    logic [MW-1:0]     r_hist [N_BINS];

    logic [MW-1:0]     w_re_ext;
    logic [MW-1:0]     w_im_ext;
    logic [MW-1:0]     w_abs_re;
    logic [MW-1:0]     w_abs_im;
    logic [MW-1:0]     w_mag;
    logic [MW-1:0]     w_hist_old;
    logic [MW-1:0]     w_diff;
    logic [FLUX_W:0]   w_sum;
    logic [FLUX_W-1:0] w_acc_next;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_next = S_READ;
            S_READ:  if (r_addr == LAST_ADDR) w_state_next = S_DRAIN;
            S_DRAIN: if (r_drain) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Sign-extend by one bit first so that abs(most-negative) fits without wrapping.
    always_comb begin
        w_re_ext = {i_rd_real[DATA_W-1], i_rd_real};
        w_im_ext = {i_rd_imag[DATA_W-1], i_rd_imag};
        w_abs_re = w_re_ext[DATA_W] ? (~w_re_ext + MW'(1)) : w_re_ext;
        w_abs_im = w_im_ext[DATA_W] ? (~w_im_ext + MW'(1)) : w_im_ext;
    end

`ifdef SPECFLUX_MAXMIN_EN
    logic [MW-1:0] w_max;
    logic [MW-1:0] w_min;
    always_comb begin
        w_max = (w_abs_re >= w_abs_im) ? w_abs_re : w_abs_im;
        w_min = (w_abs_re >= w_abs_im) ? w_abs_im : w_abs_re;
        w_mag = w_max + (w_min >> 1);
    end
`else
    always_comb begin
        w_mag = w_abs_re + w_abs_im;
    end
`endif

    // The extra sum bit flags overflow so the accumulator sticks at all-ones.
    always_comb begin
        w_hist_old = r_hist[r_mag_idx];
        w_diff     = (r_mag > w_hist_old) ? (r_mag - w_hist_old) : '0;
        w_sum      = {1'b0, r_acc} + (FLUX_W + 1)'(w_diff);
        w_acc_next = r_acc;
        if (r_mag_vld) w_acc_next = w_sum[FLUX_W] ? '1 : w_sum[FLUX_W-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_drain   <= 1'b0;
            r_rd_vld  <= 1'b0;
            r_rd_idx  <= '0;
            r_mag_vld <= 1'b0;
            r_mag     <= '0;
            r_mag_idx <= '0;
            r_acc     <= '0;
            r_flux    <= '0;
            for (int i = 0; i < N_BINS; i++) r_hist[i] <= '0;
        end else begin
            r_state   <= w_state_next;
            r_addr    <= (r_state == S_READ && r_addr != LAST_ADDR) ? r_addr + AW'(1) : '0;
            r_drain   <= (r_state == S_DRAIN) ? ~r_drain : 1'b0;
            r_rd_vld  <= (r_state == S_READ);
            r_rd_idx  <= r_addr;
            r_mag_vld <= r_rd_vld;
            r_mag     <= w_mag;
            r_mag_idx <= r_rd_idx;
            if (r_state == S_IDLE && i_start) r_acc <= '0;
            else                               r_acc <= w_acc_next;
            if (r_mag_vld) r_hist[r_mag_idx] <= r_mag;
            // Last bin accumulates in the final drain cycle; capture it straight into the output.
            if (r_state == S_DRAIN && r_drain) r_flux <= w_acc_next;
        end
    end

    assign o_rd_en      = (r_state == S_READ);
    assign o_rd_addr    = r_addr;
    assign o_busy       = (r_state != S_IDLE);
    assign o_flux       = r_flux;
    assign o_flux_valid = (r_state == S_DONE);

endmodule

// File: tb/tb_spectral_flux_calc.sv
// Directed bench for spectral_flux_calc with a one-cycle-latency FFT memory model.
module tb_spectral_flux_calc;

    localparam int N  = 128;
    localparam int DW = 16;
    localparam int FW = 32;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_start = 1'b0;
    logic          o_rd_en;
    logic [AW-1:0] o_rd_addr;
    logic [DW-1:0] i_rd_real = '0;
    logic [DW-1:0] i_rd_imag = '0;
    logic          o_busy;
    logic [FW-1:0] o_flux;
    logic          o_flux_valid;

    logic [DW-1:0] mem_re [N];
    logic [DW-1:0] mem_im [N];

    int n_checks = 0;
    int n_fails  = 0;

    spectral_flux_calc #(.N_BINS(N), .DATA_W(DW), .FLUX_W(FW)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
        .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
        .i_rd_real(i_rd_real), .i_rd_imag(i_rd_imag),
        .o_busy(o_busy), .o_flux(o_flux), .o_flux_valid(o_flux_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_rd_en) begin
            i_rd_real <= mem_re[o_rd_addr];
            i_rd_imag <= mem_im[o_rd_addr];
        end
    end

    task automatic fill_mem(input logic [DW-1:0] re, input logic [DW-1:0] im);
        for (int i = 0; i < N; i++) begin
            mem_re[i] = re;
            mem_im[i] = im;
        end
    endtask

    task automatic run_frame(input string name, input logic [FW-1:0] exp_flux, input int glitch_cyc);
        int vcnt = 0;
        int vcyc = -1;
        int sweep_err = 0;
        int busy_err = 0;
        logic [FW-1:0] flux_seen = '0;
        logic [AW-1:0] exp_addr;
        @(negedge clk);
        i_start = 1'b1;
        for (int cyc = 1; cyc <= N + 6; cyc++) begin
            @(negedge clk);
            i_start = (cyc == glitch_cyc);
            exp_addr = AW'(cyc - 1);
            if (cyc <= N) begin
                if (o_rd_en !== 1'b1 || o_rd_addr !== exp_addr) sweep_err++;
            end else if (o_rd_en !== 1'b0 || o_rd_addr !== '0) begin
                sweep_err++;
            end
            if (o_busy !== (cyc <= N + 3)) busy_err++;
            if (o_flux_valid === 1'b1) begin
                vcnt++;
                vcyc = cyc;
                flux_seen = o_flux;
            end
        end
        i_start = 1'b0;
        n_checks++;
        if (sweep_err !== 0) begin
            n_fails++;
            $display("FAIL %s addr_sweep: %0d bad cycles, required 0", name, sweep_err);
        end
        n_checks++;
        if (busy_err !== 0) begin
            n_fails++;
            $display("FAIL %s busy_window: %0d bad cycles, required 0", name, busy_err);
        end
        n_checks++;
        if (vcnt !== 1) begin
            n_fails++;
            $display("FAIL %s valid_count: got %0d, required 1", name, vcnt);
        end
        n_checks++;
        if (vcyc !== N + 3) begin
            n_fails++;
            $display("FAIL %s valid_cycle: got %0d, required %0d", name, vcyc, N + 3);
        end
        n_checks++;
        if (flux_seen !== exp_flux) begin
            n_fails++;
            $display("FAIL %s flux: got %0d, required %0d", name, flux_seen, exp_flux);
        end
        n_checks++;
        if (o_flux !== exp_flux) begin
            n_fails++;
            $display("FAIL %s flux_held: got %0d, required %0d", name, o_flux, exp_flux);
        end
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({o_rd_en, o_rd_addr, o_busy, o_flux, o_flux_valid} !== '0) begin
            n_fails++;
            $display("FAIL reset_outputs: en=%0d addr=%0d busy=%0d flux=%0d valid=%0d, required all 0",
                     o_rd_en, o_rd_addr, o_busy, o_flux, o_flux_valid);
        end
        i_rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0 || o_flux_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL idle_after_reset: busy=%0d valid=%0d, required 0 0", o_busy, o_flux_valid);
        end
    endtask

    task automatic test_frames;
        fill_mem(16'd100, 16'd0);
        run_frame("frame1", 32'd12800, 0);
        run_frame("frame2", 32'd0, 0);
        mem_re[5] = 16'hFED4;  // -300
        mem_im[5] = 16'd400;
`ifdef SPECFLUX_MAXMIN_EN
        run_frame("frame3", 32'd450, 0);
`else
        run_frame("frame3", 32'd600, 0);
`endif
        fill_mem(16'd0, 16'd0);
        run_frame("frame4", 32'd0, 0);
    endtask

    task automatic test_min_values;
        i_rst = 1'b1;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        fill_mem(16'h8000, 16'h8000);
`ifdef SPECFLUX_MAXMIN_EN
        run_frame("min_values", 32'd6291456, 0);
`else
        run_frame("min_values", 32'd8388608, 0);
`endif
    endtask

    task automatic test_start_ignored;
        // History now holds large magnitudes, so a 100/0 frame yields zero flux.
        fill_mem(16'd100, 16'd0);
        run_frame("start_ignored", 32'd0, 40);
    endtask

    task automatic test_mid_reset;
        int vcnt = 0;
        int busy_err = 0;
        fill_mem(16'd100, 16'd0);
        run_frame("pre_reset", 32'd0, 0);
        @(negedge clk);
        i_start = 1'b1;
        for (int cyc = 1; cyc <= N + 8; cyc++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (cyc == 50) i_rst = 1'b1;
            if (cyc == 51) begin
                i_rst = 1'b0;
                n_checks++;
                if (o_busy !== 1'b0 || o_rd_en !== 1'b0 || o_flux !== '0) begin
                    n_fails++;
                    $display("FAIL mid_reset_state: busy=%0d en=%0d flux=%0d, required 0 0 0",
                             o_busy, o_rd_en, o_flux);
                end
            end
            if (cyc > 51 && o_busy !== 1'b0) busy_err++;
            if (o_flux_valid === 1'b1) vcnt++;
        end
        n_checks++;
        if (vcnt !== 0) begin
            n_fails++;
            $display("FAIL mid_reset_no_valid: got %0d pulses, required 0", vcnt);
        end
        n_checks++;
        if (busy_err !== 0) begin
            n_fails++;
            $display("FAIL mid_reset_stays_idle: %0d busy cycles, required 0", busy_err);
        end
        run_frame("post_reset", 32'd12800, 0);
    endtask

    initial begin
        fill_mem(16'd0, 16'd0);
        test_reset();
        test_frames();
        test_min_values();
        test_start_ignored();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
